// File: rtl/cmd_sched.sv
// -----------------------------------------------------------------------------
// cmd_sched
//
// Purpose:
//   Command scheduler between the command sources and the life engine. Manual
//   commands arrive as single-cycle strobes and are buffered in a small FIFO.
//   An optional periodic auto-advance requester can be merged in. Exactly one
//   command is offered to the engine at a time over a valid/ready handshake.
//   After acceptance, the scheduler waits for eng_done before it offers the
//   next command.
//
// Build option:
//   CMD_SCHED_AUTORUN_EN -- when defined, the auto-run timer, the sticky
//   auto_pending flag and the autorun_toggle logic are built. When it is
//   undefined, autorun_toggle is ignored and autorun_active reads 0. All
//   manual behaviour is the same in both builds.
//
// Parameters:
//   FIFO_DEPTH_LOG2 : manual FIFO holds 2^N entries of {cmd, arg0} (N >= 1)
//   AUTO_PERIOD     : clk ticks between auto-advance requests (>= 2)
//
// Ports:
//   clk, reset       : clock; asynchronous active-high reset
//   req_cmd/arg0     : manual command payload
//   req_valid        : single-cycle strobe; there is no backpressure
//   req_drop         : registered pulse, a manual command was lost (FIFO full)
//   autorun_toggle   : single-cycle strobe that flips auto-run mode
//   autorun_active   : auto-run mode flag
//   eng_cmd/arg0     : payload to the engine; holds the last value when idle
//   eng_valid        : command offered to the engine
//   eng_ready        : engine accepts when eng_valid & eng_ready
//   eng_done         : single-cycle pulse, the accepted command has finished
//   busy             : FIFO non-empty, command in flight, or auto request pending
// -----------------------------------------------------------------------------
module cmd_sched #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int AUTO_PERIOD     = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_arg0,
  input  logic        req_valid,
  output logic        req_drop,
  input  logic        autorun_toggle,
  output logic        autorun_active,
  output logic [2:0]  eng_cmd,
  output logic [31:0] eng_arg0,
  output logic        eng_valid,
  input  logic        eng_ready,
  input  logic        eng_done,
  output logic        busy
);

  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

  // Command code issued for auto-advance requests (CMD_ADVANCE).
  localparam logic [2:0] CMD_ADVANCE = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic        drop_q, drop_d;

  // ---------------------------------------------------------------------------
  // Manual FIFO
  // ---------------------------------------------------------------------------
  logic [34:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          auto_clear;
  logic          auto_pending;
  logic [34:0]   fifo_head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push = req_valid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    drop_d = req_valid && !push;
  end

  // The storage has no reset. A reset flushes the FIFO by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {req_cmd, req_arg0};
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    pop        = 1'b0;
    auto_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Manual commands always win over a pending auto request.
        if (!fifo_empty) begin
          pop            = 1'b1;
          {cmd_d, arg_d} = fifo_head;
          state_d        = ST_ISSUE;
        end else if (auto_pending) begin
          cmd_d      = CMD_ADVANCE;
          arg_d      = 32'd1;
          auto_clear = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (eng_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (eng_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      arg_q    <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-advance requester
  // ---------------------------------------------------------------------------
`ifdef CMD_SCHED_AUTORUN_EN
  localparam logic [31:0] TIMER_LAST = 32'(AUTO_PERIOD - 1);

  logic [31:0] timer_q, timer_d;
  logic        active_q, active_d;
  logic        pending_q, pending_d;

  always_comb begin
    active_d  = active_q ^ autorun_toggle;
    timer_d   = timer_q;
    pending_d = pending_q;
    // If the FSM consumes the flag and a new expiry happens in the same
    // cycle, the flag stays set. So the clear is applied first.
    if (auto_clear) pending_d = 1'b0;
    if (active_q) begin
      if (timer_q == TIMER_LAST) begin
        timer_d   = '0;
        pending_d = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
    // Turning auto-run off discards the partial period and any unserved
    // request on the same edge.
    if (autorun_toggle && active_q) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign auto_pending   = pending_q;
  assign autorun_active = active_q;
`else
  logic unused_autorun;
  assign unused_autorun = autorun_toggle | auto_clear | (AUTO_PERIOD < 2);
  assign auto_pending   = 1'b0;
  assign autorun_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign eng_valid = (state_q == ST_ISSUE);
  assign eng_cmd   = cmd_q;
  assign eng_arg0  = arg_q;
  assign req_drop  = drop_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE) || auto_pending;

endmodule

// File: tb/tb_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_cmd_sched
//
// Directed and randomized stimulus for cmd_sched. A transaction-level
// reference model runs alongside the DUT. The model keeps a queue of
// buffered commands, an engine slot (free / offered / outstanding), and the
// auto-run timer rules. Every cycle the DUT outputs are compared against the
// model. Directed steps add explicit expectations for latency, stall hold,
// overflow, auto-run behaviour and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_cmd_sched;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 10;
  localparam logic [2:0] CMD_SEED      = 3'd1;
  localparam logic [2:0] CMD_ADVANCE   = 3'd2;
  localparam logic [2:0] CMD_READ_CELL = 3'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_cmd = '0;
  logic [31:0] req_arg0 = '0;
  logic        req_valid = 1'b0;
  logic        req_drop;
  logic        autorun_toggle = 1'b0;
  logic        autorun_active;
  logic [2:0]  eng_cmd;
  logic [31:0] eng_arg0;
  logic        eng_valid;
  logic        eng_ready = 1'b0;
  logic        eng_done = 1'b0;
  logic        busy;

  cmd_sched #(
    .FIFO_DEPTH_LOG2(2),
    .AUTO_PERIOD    (PERIOD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_cmd       (req_cmd),
    .req_arg0      (req_arg0),
    .req_valid     (req_valid),
    .req_drop      (req_drop),
    .autorun_toggle(autorun_toggle),
    .autorun_active(autorun_active),
    .eng_cmd       (eng_cmd),
    .eng_arg0      (eng_arg0),
    .eng_valid     (eng_valid),
    .eng_ready     (eng_ready),
    .eng_done      (eng_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [34:0] m_q[$];
  int          m_slot;      // 0 free, 1 offered, 2 outstanding
  logic [2:0]  m_cmd;
  logic [31:0] m_arg;
  logic        m_drop;
  logic        m_active;
  logic        m_pending;
  int          m_timer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_slot    = 0;
    m_cmd     = '0;
    m_arg     = '0;
    m_drop    = 1'b0;
    m_active  = 1'b0;
    m_pending = 1'b0;
    m_timer   = 0;
  endtask

  // Apply the scheduling rules for one clock edge, using the inputs that
  // were held during the cycle that just ended.
  task automatic model_edge();
    bit clr;
    bit np;
    clr    = 1'b0;
    m_drop = 1'b0;
    case (m_slot)
      0: begin
        if (m_q.size() > 0) begin
          {m_cmd, m_arg} = m_q.pop_front();
          m_slot = 1;
        end else if (m_pending) begin
          m_cmd  = CMD_ADVANCE;
          m_arg  = 32'd1;
          m_slot = 1;
          clr    = 1'b1;
        end
      end
      1: begin
        if (eng_ready) begin
          m_slot = 2;
          $display("[TB] cycle %0d: engine accepted cmd=%0d arg0=0x%08h", cyc, m_cmd, m_arg);
        end
      end
      default: if (eng_done) m_slot = 0;
    endcase
    if (req_valid) begin
      if (m_q.size() < DEPTH) m_q.push_back({req_cmd, req_arg0});
      else m_drop = 1'b1;
    end
`ifdef CMD_SCHED_AUTORUN_EN
    np = m_pending && !clr;
    if (m_active) begin
      if (m_timer == PERIOD - 1) begin
        m_timer = 0;
        np = 1'b1;
      end else begin
        m_timer++;
      end
    end
    if (autorun_toggle) begin
      if (m_active) begin
        m_timer = 0;
        np = 1'b0;
      end
      m_active = !m_active;
    end
    m_pending = np;
`else
    np = clr;
`endif
  endtask

  // One clock: update the model at the edge and compare the outputs 1 time
  // unit later. Then drop the single-cycle strobes.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("eng_valid", eng_valid, m_slot == 1);
    chk("eng_cmd", eng_cmd, m_cmd);
    chk("eng_arg0", eng_arg0, m_arg);
    chk("req_drop", req_drop, m_drop);
    chk("autorun_active", autorun_active, m_active);
    chk("busy", busy, (m_q.size() > 0) || (m_slot != 0) || m_pending);
    req_valid      = 1'b0;
    autorun_toggle = 1'b0;
    eng_done       = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n;
    n = 0;
    while (!eng_valid && n < max) begin
      cycle();
      n++;
    end
    chk(tag, eng_valid, 1'b1);
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] a);
    req_cmd   = c;
    req_arg0  = a;
    req_valid = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int last;
    int nadv;
    int cd;
    m_reset();

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_eng_valid", eng_valid, 1'b0);
    chk("rst_eng_cmd", eng_cmd, 3'd0);
    chk("rst_eng_arg0", eng_arg0, 32'd0);
    chk("rst_req_drop", req_drop, 1'b0);
    chk("rst_autorun", autorun_active, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    cycle();

    // ---------------- T1: manual latency ----------------
    eng_ready = 1'b1;
    send(CMD_SEED, 32'h0000_0000);
    cycle();
    chk("t1_valid_n1", eng_valid, 1'b0);
    chk("t1_busy_n1", busy, 1'b1);
    cycle();
    chk("t1_valid_n2", eng_valid, 1'b1);
    chk("t1_cmd", eng_cmd, CMD_SEED);
    chk("t1_arg", eng_arg0, 32'd0);
    cycle();
    chk("t1_valid_n3", eng_valid, 1'b0);
    repeat (3) cycle();
    chk("t1_busy_wait", busy, 1'b1);
    eng_done = 1'b1;
    cycle();
    chk("t1_busy_done", busy, 1'b0);

    // ---------------- T2: stall holds payload ----------------
    eng_ready = 1'b0;
    send(CMD_READ_CELL, 32'hA5A5_0F0F);
    cycle();
    cycle();
    chk("t2_valid", eng_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_hold_valid", eng_valid, 1'b1);
      chk("t2_hold_cmd", eng_cmd, CMD_READ_CELL);
      chk("t2_hold_arg", eng_arg0, 32'hA5A5_0F0F);
    end
    eng_ready = 1'b1;
    cycle();
    chk("t2_after_hs", eng_valid, 1'b0);
    chk("t2_payload_kept", eng_arg0, 32'hA5A5_0F0F);
    eng_done = 1'b1;
    cycle();

    // ---------------- T3: overflow and order ----------------
    send(CMD_SEED, 32'h99);
    cycle();
    cycle();
    cycle();  // handshake -> waiting for done
    for (int k = 1; k <= 6; k++) begin
      send(CMD_READ_CELL, k);
      cycle();
      chk("t3_drop", req_drop, k >= 5);
    end
    for (int k = 1; k <= 4; k++) begin
      eng_done = 1'b1;
      cycle();
      wait_valid(5, "t3_issue_timeout");
      chk("t3_order_arg", eng_arg0, k);
      cycle();
    end
    eng_done = 1'b1;
    cycle();
    chk("t3_idle_busy", busy, 1'b0);

`ifdef CMD_SCHED_AUTORUN_EN
    // ---------------- T4: periodic auto-advance ----------------
    autorun_toggle = 1'b1;
    cycle();
    chk("t4_active", autorun_active, 1'b1);
    last = -1;
    nadv = 0;
    cd   = 0;
    for (int i = 0; i < 45; i++) begin
      if (cd == 1) eng_done = 1'b1;
      if (cd > 0) cd--;
      cycle();
      if (eng_valid) begin
        chk("t4_cmd", eng_cmd, CMD_ADVANCE);
        chk("t4_arg", eng_arg0, 32'd1);
        if (last >= 0) chk("t4_period", cyc - last, PERIOD);
        last = cyc;
        nadv++;
        cd = 2;
      end
    end
    chk("t4_count", nadv, 4);
    autorun_toggle = 1'b1;
    cycle();
    chk("t4_off", autorun_active, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (eng_valid) n++;
    end
    chk("t4_no_more", n, 0);
    chk("t4_busy", busy, 1'b0);

    // ---------------- T5: priority and coalescing ----------------
    send(CMD_SEED, 32'h55);
    cycle();
    cycle();
    cycle();                     // long command outstanding
    autorun_toggle = 1'b1;
    cycle();                     // E0
    repeat (29) cycle();         // expiries at E0+10, E0+20
    send(CMD_READ_CELL, 32'd7);
    cycle();                     // E0+30, third expiry
    eng_done = 1'b1;
    cycle();                     // E0+31
    cycle();                     // E0+32
    chk("t5_first_valid", eng_valid, 1'b1);
    chk("t5_first_cmd", eng_cmd, CMD_READ_CELL);
    chk("t5_first_arg", eng_arg0, 32'd7);
    cycle();                     // handshake
    eng_done = 1'b1;
    cycle();
    cycle();                     // E0+35
    chk("t5_second_valid", eng_valid, 1'b1);
    chk("t5_second_cmd", eng_cmd, CMD_ADVANCE);
    chk("t5_second_arg", eng_arg0, 32'd1);
    cycle();
    eng_done = 1'b1;
    cycle();
    autorun_toggle = 1'b1;
    cycle();                     // E0+38, before the next expiry
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (eng_valid) n++;
    end
    chk("t5_single_advance", n, 0);
    chk("t5_busy", busy, 1'b0);
`else
    // ---------------- auto-run absent: toggle is ignored ----------------
    autorun_toggle = 1'b1;
    cycle();
    chk("noauto_active", autorun_active, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (eng_valid) n++;
    end
    chk("noauto_no_issue", n, 0);
    chk("noauto_busy", busy, 1'b0);
`endif

    // ---------------- T6: asynchronous reset mid-operation ----------------
    send(CMD_SEED, 32'h11);
    cycle();
    cycle();
    cycle();                     // outstanding
    send(CMD_READ_CELL, 32'h22);
    cycle();
    send(CMD_READ_CELL, 32'h33);
    autorun_toggle = 1'b1;
    cycle();
    chk("t6_busy_before", busy, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_eng_valid", eng_valid, 1'b0);
    chk("t6_eng_cmd", eng_cmd, 3'd0);
    chk("t6_eng_arg0", eng_arg0, 32'd0);
    chk("t6_req_drop", req_drop, 1'b0);
    chk("t6_autorun", autorun_active, 1'b0);
    chk("t6_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (eng_valid) n++;
    end
    chk("t6_no_issue", n, 0);

    // ---------------- random phase ----------------
    for (int i = 0; i < 400; i++) begin
      req_valid      = ($urandom_range(0, 99) < 40);
      req_cmd        = 3'($urandom_range(1, 3));
      req_arg0       = $urandom;
      eng_ready      = 1'($urandom_range(0, 1));
      eng_done       = ($urandom_range(0, 99) < 30);
      autorun_toggle = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
